// File: rtl/rot_pkg.sv
// rtl/rot_pkg.sv - shared types and widths for the rotate command path
package rot_pkg;

  localparam int ROT_DATA_W = 32;
  localparam int ROT_AMT_W  = 5;

  typedef struct packed {
    logic [ROT_DATA_W-1:0] data;
    logic [ROT_AMT_W-1:0]  shift;
    logic                  left;
  } rot_cmd_t;

  localparam int ROT_CMD_W = $bits(rot_cmd_t);

  // Value presented to the rotator when no command is queued.
  localparam rot_cmd_t ROT_IDLE_CMD = '{data: '0, shift: '0, left: 1'b1};

endpackage

// File: rtl/rot_cmd_fifo.sv
// rtl/rot_cmd_fifo.sv - synchronous command FIFO with explicit occupancy count
module rot_cmd_fifo
  import rot_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  rot_cmd_t         wdata_i,
  input  logic             pop_i,
  output rot_cmd_t         rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W:0]   level_o
);

  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

  rot_cmd_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // No full-bypass: a full FIFO refuses a push even if it pops this cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (PTR_W+1)'(1);
      2'b01:   level_d = level_q - (PTR_W+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/rot_cmd_issue_stage.sv
// rtl/rot_cmd_issue_stage.sv - buffers rotate commands, drives the rotator, registers results
module rot_cmd_issue_stage
  import rot_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROT_DATA_W-1:0] in_data,
  input  logic [ROT_AMT_W-1:0]  in_shift,
  input  logic                  in_left,
  output logic [ROT_DATA_W-1:0] rot_data,
  output logic [ROT_AMT_W-1:0]  rot_shift,
  output logic                  rot_sel,
  input  logic [ROT_DATA_W-1:0] rot_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ROT_DATA_W-1:0] out_data,
  output logic [PTR_W:0]        level
);

  rot_cmd_t              wr_cmd;
  rot_cmd_t              head_cmd;
  rot_cmd_t              drive_cmd;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  issue;
  logic                  out_valid_q, out_valid_d;
  logic [ROT_DATA_W-1:0] out_data_q, out_data_d;

  assign wr_cmd = '{data: in_data, shift: in_shift, left: in_left};

  assign in_ready = rst_n & ~fifo_full;
  assign push     = in_valid & in_ready;
  assign issue    = ~fifo_empty & (~out_valid_q | out_ready);

  rot_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (wr_cmd),
    .pop_i   (issue),
    .rdata_o (head_cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  // Park the rotator on a known value so its output is quiet when idle.
  assign drive_cmd = fifo_empty ? ROT_IDLE_CMD : head_cmd;
  assign rot_data  = drive_cmd.data;
  assign rot_shift = drive_cmd.shift;
  assign rot_sel   = drive_cmd.left;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (issue) begin
      out_valid_d = 1'b1;
      out_data_d  = rot_result;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
